// File: rtl/pcs_pkg.sv
// Shared constants and types for the 64b/66b transmit encoder:
// XGMII characters, BASE-R block types, sync headers, FSM state codes
// and the input word classification.
package pcs_pkg;

  localparam int DATA_WIDTH = 64;
  localparam int CTRL_WIDTH = DATA_WIDTH / 8;
  localparam int HDR_WIDTH  = 2;

  // XGMII control characters
  localparam logic [7:0] XG_IDLE  = 8'h07;
  localparam logic [7:0] XG_START = 8'hFB;
  localparam logic [7:0] XG_TERM  = 8'hFD;
  localparam logic [7:0] XG_ERROR = 8'hFE;

  // 7-bit control codes used inside control blocks
  localparam logic [6:0] CC_IDLE  = 7'h00;
  localparam logic [6:0] CC_ERROR = 7'h1E;

  // Block type field values
  localparam logic [7:0] BT_CTRL  = 8'h1E;
  localparam logic [7:0] BT_START = 8'h78;
  localparam logic [7:0] BT_TERM [0:7] = '{8'h87, 8'h99, 8'hAA, 8'hB4,
                                            8'hCC, 8'hD2, 8'hE1, 8'hFF};

  // Sync headers
  localparam logic [HDR_WIDTH-1:0] SH_DATA = 2'b01;
  localparam logic [HDR_WIDTH-1:0] SH_CTRL = 2'b10;

  // Canned payloads
  localparam logic [DATA_WIDTH-1:0] IDLE_BLOCK = {56'h0, BT_CTRL};
  localparam logic [DATA_WIDTH-1:0] ERR_BLOCK  = {{8{CC_ERROR}}, BT_CTRL};

  // Encoder FSM state codes
  localparam logic [2:0] ST_INIT = 3'd0;
  localparam logic [2:0] ST_TX_C = 3'd1;
  localparam logic [2:0] ST_TX_D = 3'd2;
  localparam logic [2:0] ST_TX_T = 3'd3;
  localparam logic [2:0] ST_TX_E = 3'd4;

  typedef enum logic [2:0] {
    INIT = ST_INIT,
    TX_C = ST_TX_C,
    TX_D = ST_TX_D,
    TX_T = ST_TX_T,
    TX_E = ST_TX_E
  } enc_state_t;

  // Classification of one XGMII word
  typedef enum logic [2:0] {
    BLK_C,  // all idle / error control characters
    BLK_S,  // start in lane 0
    BLK_D,  // all data
    BLK_T,  // terminate in some lane, idles after it
    BLK_E   // anything else
  } blk_class_t;

endpackage

// File: rtl/pcs_encoder_64b66b_if.sv
// XGMII-side input word and BASE-R block output bundle of the encoder.
// Optional o_err_cnt is present only when PCS_ENC_ERR_CNT_EN is defined.
interface pcs_encoder_64b66b_if;

  logic                             i_valid;
  logic [pcs_pkg::DATA_WIDTH-1:0]   i_tx_data;
  logic [pcs_pkg::CTRL_WIDTH-1:0]   i_tx_ctrl;
  logic                             o_valid;
  logic [pcs_pkg::HDR_WIDTH-1:0]    o_tx_hdr;
  logic [pcs_pkg::DATA_WIDTH-1:0]   o_tx_data;
`ifdef PCS_ENC_ERR_CNT_EN
  logic [15:0]                      o_err_cnt;
`endif

  // Encoder side
  modport slave (
    input  i_valid, i_tx_data, i_tx_ctrl,
    output o_valid, o_tx_hdr, o_tx_data
`ifdef PCS_ENC_ERR_CNT_EN
    , output o_err_cnt
`endif
  );

  // Word source / block sink side
  modport master (
    output i_valid, i_tx_data, i_tx_ctrl,
    input  o_valid, o_tx_hdr, o_tx_data
`ifdef PCS_ENC_ERR_CNT_EN
    , input o_err_cnt
`endif
  );

endinterface

// File: rtl/pcs_enc_classify.sv
// Combinational classifier: XGMII data+ctrl -> block class, terminate lane
// and encoded payload. For terminate words the type byte is left zero; the
// top picks it from the lane index.
module pcs_enc_classify
  import pcs_pkg::*;
(
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic [CTRL_WIDTH-1:0] tx_ctrl,
  output blk_class_t            blk_class,
  output logic [2:0]            term_lane,
  output logic [DATA_WIDTH-1:0] payload
);

  logic                  is_c;
  logic                  is_t;
  logic [DATA_WIDTH-1:0] c_payload;
  logic [DATA_WIDTH-1:0] t_payload;

  // Control word check and 7-bit code packing
  // NOTE: every variable written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    is_c      = (tx_ctrl == 8'hFF);
    c_payload = IDLE_BLOCK;
    for (int k = 0; k < 8; k++) begin
      if (tx_data[8*k +: 8] == XG_ERROR) begin
        c_payload[8 + 7*k +: 7] = CC_ERROR;
      end else begin
        c_payload[8 + 7*k +: 7] = CC_IDLE;
        if (tx_data[8*k +: 8] != XG_IDLE) is_c = 1'b0;
      end
    end
  end

  // Terminate detection: ctrl is ones from lane k up, lane k is /T/, idles after
  always_comb begin
    logic       ok;
    logic [7:0] mask;
    is_t      = 1'b0;
    term_lane = 3'd0;
    for (int k = 0; k < 8; k++) begin
      mask = 8'hFF << k;
      ok   = (tx_ctrl == mask) && (tx_data[8*k +: 8] == XG_TERM);
      for (int j = k + 1; j < 8; j++) begin
        if (tx_data[8*j +: 8] != XG_IDLE) ok = 1'b0;
      end
      if (ok) begin
        is_t      = 1'b1;
        term_lane = 3'(k);
      end
    end
  end

  // Terminate payload: data lanes before the /T/ shifted up one byte
  always_comb begin
    t_payload = '0;
    for (int j = 0; j < 7; j++) begin
      if (j < int'(term_lane)) t_payload[8*j + 8 +: 8] = tx_data[8*j +: 8];
    end
  end

  // Final class selection
  always_comb begin
    blk_class = BLK_E;
    payload   = ERR_BLOCK;
    if (is_c) begin
      blk_class = BLK_C;
      payload   = c_payload;
    end else if (tx_ctrl == 8'h01 && tx_data[7:0] == XG_START) begin
      blk_class = BLK_S;
      payload   = {tx_data[63:8], BT_START};
    end else if (tx_ctrl == 8'h00) begin
      blk_class = BLK_D;
      payload   = tx_data;
    end else if (is_t) begin
      blk_class = BLK_T;
      payload   = t_payload;
    end
  end

endmodule

// File: rtl/pcs_encoder_64b66b.sv
// 64b/66b BASE-R transmit encoder: classifies XGMII words, runs the
// transmit encode FSM, substitutes error blocks on illegal sequences and
// registers the 66-bit block with one cycle of latency.
// Optional feature macro: PCS_ENC_ERR_CNT_EN (saturating error block count).
module pcs_encoder_64b66b
  import pcs_pkg::*;
(
  input  logic                   clk,
  input  logic                   i_rst_n,
  pcs_encoder_64b66b_if.slave    bus
);

  blk_class_t            cls;
  logic [2:0]            term_lane;
  logic [DATA_WIDTH-1:0] cls_payload;

  enc_state_t            state_q;
  enc_state_t            state_d;
  logic                  take_c;
  logic                  take_s;
  logic                  take_d;
  logic                  take_t;
  logic [HDR_WIDTH-1:0]  hdr_d;
  logic [DATA_WIDTH-1:0] data_d;

  logic                  valid_q;
  logic [HDR_WIDTH-1:0]  hdr_q;
  logic [DATA_WIDTH-1:0] data_q;

  pcs_enc_classify u_classify (
    .tx_data   (bus.i_tx_data),
    .tx_ctrl   (bus.i_tx_ctrl),
    .blk_class (cls),
    .term_lane (term_lane),
    .payload   (cls_payload)
  );

  // Which classes are legal from the current state
  always_comb begin
    take_c = 1'b0;
    take_s = 1'b0;
    take_d = 1'b0;
    take_t = 1'b0;
    case (state_q)
      INIT, TX_C, TX_T: begin
        take_c = (cls == BLK_C);
        take_s = (cls == BLK_S);
      end
      TX_D: begin
        take_d = (cls == BLK_D);
        take_t = (cls == BLK_T);
      end
      TX_E: begin
        take_c = (cls == BLK_C);
        take_d = (cls == BLK_D);
        take_t = (cls == BLK_T);
      end
      default: ;
    endcase
  end

  // Next block and state; anything not accepted becomes an error block
  always_comb begin
    state_d = TX_E;
    hdr_d   = SH_CTRL;
    data_d  = ERR_BLOCK;
    if (take_c) begin
      state_d = TX_C;
      data_d  = cls_payload;
    end else if (take_s) begin
      state_d = TX_D;
      data_d  = cls_payload;
    end else if (take_d) begin
      state_d = TX_D;
      hdr_d   = SH_DATA;
      data_d  = cls_payload;
    end else if (take_t) begin
      state_d = TX_T;
      data_d  = {cls_payload[63:8], BT_TERM[term_lane]};
    end
  end

  // Output block and FSM registers; held while i_valid is low
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_q <= 1'b0;
      hdr_q   <= SH_CTRL;
      data_q  <= IDLE_BLOCK;
      state_q <= INIT;
    end else begin
      valid_q <= bus.i_valid;
      if (bus.i_valid) begin
        hdr_q   <= hdr_d;
        data_q  <= data_d;
        state_q <= state_d;
      end
    end
  end

  assign bus.o_valid   = valid_q;
  assign bus.o_tx_hdr  = hdr_q;
  assign bus.o_tx_data = data_q;

`ifdef PCS_ENC_ERR_CNT_EN
  logic        err_blk;
  logic [15:0] err_cnt_q;

  assign err_blk = ~(take_c | take_s | take_d | take_t);

  // Saturating count of error blocks emitted
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      err_cnt_q <= 16'd0;
    end else if (bus.i_valid && err_blk && err_cnt_q != 16'hFFFF) begin
      err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  assign bus.o_err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_pcs_encoder_64b66b.sv
// Self-checking bench for pcs_encoder_64b66b: directed test-plan sequence
// with literal expectations, then randomized words against a behavioural
// model, with one compare process checking every cycle.
module tb_pcs_encoder_64b66b;

  logic clk = 1'b0;
  logic i_rst_n;
  always #5 clk = ~clk;

  pcs_encoder_64b66b_if bus ();

  pcs_encoder_64b66b dut (
    .clk     (clk),
    .i_rst_n (i_rst_n),
    .bus     (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // States: 0 INIT, 1 after control, 2 in frame, 3 after terminate, 4 after error
  typedef struct {
    int          st;
    logic [1:0]  hdr;
    logic [63:0] data;
    bit          err;
  } step_t;

  function automatic step_t ref_step(input int st, input logic [63:0] d, input logic [7:0] c);
    step_t       r;
    logic [7:0]  ln [8];
    logic [7:0]  tt [8];
    int          cls;
    int          tk;
    bit          ok;
    bit          legal;
    logic [63:0] p;
    tt = '{8'h87, 8'h99, 8'hAA, 8'hB4, 8'hCC, 8'hD2, 8'hE1, 8'hFF};
    for (int i = 0; i < 8; i++) ln[i] = d[8*i +: 8];
    cls = 4;
    tk  = 0;
    ok  = (c == 8'hFF);
    for (int i = 0; i < 8; i++) if (ln[i] != 8'h07 && ln[i] != 8'hFE) ok = 0;
    if (ok) cls = 0;
    else if (c == 8'h01 && ln[0] == 8'hFB) cls = 1;
    else if (c == 8'h00) cls = 2;
    else begin
      for (int k = 0; k < 8; k++) begin
        ok = (c == 8'(8'hFF << k)) && (ln[k] == 8'hFD);
        for (int j = k + 1; j < 8; j++) if (ln[j] != 8'h07) ok = 0;
        if (ok) begin
          cls = 3;
          tk  = k;
        end
      end
    end
    legal = ((st == 0 || st == 1 || st == 3) && (cls == 0 || cls == 1)) ||
            (st == 2 && (cls == 2 || cls == 3)) ||
            (st == 4 && (cls == 0 || cls == 2 || cls == 3));
    p = 64'h1E;
    case (cls)
      0: for (int i = 0; i < 8; i++) if (ln[i] == 8'hFE) p = p | (64'(7'h1E) << (8 + 7*i));
      1: p = {d[63:8], 8'h78};
      2: p = d;
      3: p = ((d & ((64'd1 << (8*tk)) - 64'd1)) << 8) | 64'(tt[tk]);
      default: p = 64'h1E;
    endcase
    if (!legal) begin
      p = 64'h1E;
      for (int i = 0; i < 8; i++) p = p | (64'(7'h1E) << (8 + 7*i));
      r.st  = 4;
      r.hdr = 2'b10;
      r.err = 1;
    end else begin
      r.st  = (cls == 0) ? 1 : (cls == 3) ? 3 : 2;
      r.hdr = (cls == 2) ? 2'b01 : 2'b10;
      r.err = 0;
    end
    r.data = p;
    return r;
  endfunction

  int          m_st;
  logic        m_valid;
  logic [1:0]  m_hdr;
  logic [63:0] m_data;
  int          m_err;
  step_t       m_next;

  always_comb m_next = ref_step(m_st, bus.i_tx_data, bus.i_tx_ctrl);

  // Model registers
  always @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      m_st    <= 0;
      m_valid <= 1'b0;
      m_hdr   <= 2'b10;
      m_data  <= 64'h1E;
      m_err   <= 0;
    end else begin
      m_valid <= bus.i_valid;
      if (bus.i_valid) begin
        m_st   <= m_next.st;
        m_hdr  <= m_next.hdr;
        m_data <= m_next.data;
        if (m_next.err && m_err < 65535) m_err <= m_err + 1;
      end
    end
  end

  // Compare process: outputs against model every cycle, away from the active edge
  always @(negedge clk) begin
    check("cmp_valid", 64'(bus.o_valid), 64'(m_valid));
    check("cmp_hdr", 64'(bus.o_tx_hdr), 64'(m_hdr));
    check("cmp_data", bus.o_tx_data, m_data);
`ifdef PCS_ENC_ERR_CNT_EN
    check("cmp_err_cnt", 64'(bus.o_err_cnt), 64'(m_err));
`endif
  end

  // ---------------- stimulus helpers ----------------
  localparam logic [63:0] W_IDLE  = 64'h0707070707070707;
  localparam logic [63:0] W_START = 64'hD5555555555555FB;
  localparam logic [63:0] W_DATA  = 64'hAAAAAAAAAAAAAAAA;
  localparam logic [63:0] W_TERM4 = 64'h070707FDAAAAAAAA;
  localparam logic [63:0] E_ERR   = 64'h3C78F1E3C78F1E1E;

  task automatic drive(input logic v, input logic [63:0] d, input logic [7:0] c);
    @(negedge clk);
    #2;
    bus.i_valid   = v;
    bus.i_tx_data = d;
    bus.i_tx_ctrl = c;
  endtask

  task automatic expect_blk(input string name, input logic v, input logic [1:0] h, input logic [63:0] d);
    @(posedge clk);
    #1;
    check({name, "_valid"}, 64'(bus.o_valid), 64'(v));
    check({name, "_hdr"}, 64'(bus.o_tx_hdr), 64'(h));
    check({name, "_data"}, bus.o_tx_data, d);
  endtask

  task automatic gen(input int st, output logic [63:0] d, output logic [7:0] c);
    int r;
    int kind;
    int k;
    r = $urandom_range(0, 99);
    if (r < 8) kind = 4;
    else if (r < 18) kind = $urandom_range(0, 3);
    else if (st == 2) kind = ($urandom_range(0, 9) < 7) ? 2 : 3;
    else kind = $urandom_range(0, 1);
    d = {$urandom, $urandom};
    c = 8'h00;
    case (kind)
      0: begin
        c = 8'hFF;
        for (int i = 0; i < 8; i++) d[8*i +: 8] = ($urandom_range(0, 7) == 0) ? 8'hFE : 8'h07;
      end
      1: begin
        c = 8'h01;
        d[7:0] = 8'hFB;
      end
      2: c = 8'h00;
      3: begin
        k = $urandom_range(0, 7);
        c = 8'(8'hFF << k);
        d[8*k +: 8] = 8'hFD;
        for (int j = k + 1; j < 8; j++) d[8*j +: 8] = 8'h07;
      end
      default: begin
        c = 8'($urandom);
        if ($urandom_range(0, 1) == 1) d[7:0] = 8'hFD;
      end
    endcase
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [63:0] d;
    logic [7:0]  c;
    i_rst_n       = 1'b0;
    bus.i_valid   = 1'b0;
    bus.i_tx_data = '0;
    bus.i_tx_ctrl = '0;
    repeat (2) @(negedge clk);
    check("rst_valid", 64'(bus.o_valid), 64'h0);
    check("rst_hdr", 64'(bus.o_tx_hdr), 64'h2);
    check("rst_data", bus.o_tx_data, 64'h1E);
    #2 i_rst_n = 1'b1;

    // Idle, start, data, terminate lane 4, idle
    drive(1, W_IDLE, 8'hFF);   expect_blk("idle", 1, 2'b10, 64'h000000000000001E);
    drive(1, W_START, 8'h01);  expect_blk("start", 1, 2'b10, 64'hD555555555555578);
    drive(1, W_DATA, 8'h00);   expect_blk("data", 1, 2'b01, W_DATA);
    drive(1, W_TERM4, 8'hF0);  expect_blk("term4", 1, 2'b10, 64'h000000AAAAAAAACC);
    drive(1, W_IDLE, 8'hFF);   expect_blk("idle2", 1, 2'b10, 64'h1E);

    // Data directly after idle -> error block
    drive(1, W_DATA, 8'h00);   expect_blk("d_after_c", 1, 2'b10, E_ERR);
    // Recover, start, then idle inside the frame -> error block
    drive(1, W_IDLE, 8'hFF);   expect_blk("recover", 1, 2'b10, 64'h1E);
    drive(1, W_START, 8'h01);  expect_blk("start2", 1, 2'b10, 64'hD555555555555578);
    drive(1, W_IDLE, 8'hFF);   expect_blk("c_in_d", 1, 2'b10, E_ERR);

    // Stall mid-frame
    drive(1, W_IDLE, 8'hFF);   expect_blk("idle3", 1, 2'b10, 64'h1E);
    drive(1, W_START, 8'h01);  expect_blk("start3", 1, 2'b10, 64'hD555555555555578);
    drive(1, 64'h0123456789ABCDEF, 8'h00);
    expect_blk("pre_stall", 1, 2'b01, 64'h0123456789ABCDEF);
    for (int i = 0; i < 3; i++) begin
      drive(0, W_IDLE, 8'hFF);
      expect_blk("stall", 0, 2'b01, 64'h0123456789ABCDEF);
    end
    drive(1, 64'hFEDCBA9876543210, 8'h00);
    expect_blk("resume", 1, 2'b01, 64'hFEDCBA9876543210);

    // Reset mid-frame, then data -> error block
    @(negedge clk);
    #2 i_rst_n = 1'b0;
    #1;
    check("midrst_valid", 64'(bus.o_valid), 64'h0);
    check("midrst_hdr", 64'(bus.o_tx_hdr), 64'h2);
    check("midrst_data", bus.o_tx_data, 64'h1E);
    drive(0, W_DATA, 8'h00);
    i_rst_n = 1'b1;
    drive(1, W_DATA, 8'h00);   expect_blk("d_after_rst", 1, 2'b10, E_ERR);

    // Randomized phase against the model
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      #2;
      i_rst_n     = ($urandom_range(0, 299) != 0);
      bus.i_valid = ($urandom_range(0, 9) != 0);
      gen(m_st, d, c);
      bus.i_tx_data = d;
      bus.i_tx_ctrl = c;
    end
    @(negedge clk);
    #2;
    i_rst_n     = 1'b1;
    bus.i_valid = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
